counter_seq_ctrl: RTL and testbench
===================================

// Module: counter_seq_ctrl
// PURPOSE
//  Sequencer for the 4-bit enable-driven counter (sync clear, +1 per enabled clk_100M cycle).
//  Issues counter_clr/counter_en so software or buttons can start, pause, stop or single-step it.
//  Counts at a programmable prescaled rate, free-running or one-shot up to a target value.
//  Sits between the board control logic and the counter; it is the only driver of counter_en/clr.
// PARAMETERS
//  DIV_W   16   width of prescaler divisor; tick period = div_q+1 clk_100M cycles
// PORTS
//  clk_100M     in   1      system clock, 100 MHz, all logic on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  start        in   1      pulse: clear counter, then run (sampled in IDLE/DONE only)
//  stop         in   1      pulse: abort to IDLE, counter value kept
//  pause        in   1      level: 1 freezes RUN (prescaler and counting held)
//  step         in   1      pulse: one counter increment, honoured in IDLE only
//  one_shot     in   1      mode, sampled at start: 1 = stop at target, 0 = free-run with wrap
//  div          in   DIV_W  prescaler divisor, sampled at start
//  target       in   4      one-shot terminal count, sampled at start
//  counter      in   4      current counter value (feedback)
//  counter_en   out  1      increment enable to counter
//  counter_clr  out  1      synchronous clear to counter
//  busy         out  1      1 in CLEAR/RUN/PAUSE/STEP
//  done         out  1      1 in DONE (one-shot reached target), held until start/stop
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, presc=0, div_q=0, target_q=0, one_shot_q=0; all outputs 0.
//  States: IDLE, CLEAR, STEP, RUN, PAUSE, DONE. Command priority: stop > start > pause > step.
//  IDLE : start -> CLEAR (latch div_q/target_q/one_shot_q); else step -> STEP; else stay.
//  CLEAR: counter_clr=1 for exactly this one cycle; presc<=0; -> RUN next cycle.
//  STEP : counter_en=1 for exactly this one cycle; -> IDLE. One step pulse = one increment.
//  RUN  : tick = (presc==div_q); presc<=tick?0:presc+1. div_q=0 -> tick every cycle.
//         counter_en = tick && !(one_shot_q && counter==target_q).
//         one_shot_q && counter==target_q -> DONE (no en that cycle). pause=1 -> PAUSE.
//         free-run: counter wraps 15->0 by itself; controller never leaves RUN except stop/pause.
//  PAUSE: counter_en=0, presc held; pause=0 -> RUN (resumes same prescaler phase).
//  DONE : done=1, counter_en=0; start -> CLEAR (restart); stop -> IDLE.
//  stop in any state -> IDLE next cycle, counter_en=0 from that cycle on, no clear issued.
//  start while busy (CLEAR/RUN/PAUSE/STEP) ignored; step outside IDLE ignored.
//  start+stop same cycle: stop wins. start+step in IDLE: start wins.
//  one_shot with target_q=0: CLEAR then RUN sees counter==0 -> DONE with zero en pulses.
//  counter_en/counter_clr never both 1; counter_en never 1 outside STEP/RUN.
//  Latency: start -> counter_clr next cycle -> first possible en two cycles after start.
//  Reset mid-operation: immediate return to reset values; counter itself not cleared by this block.
//  div/target/one_shot changes after start have no effect until next start.
// STRUCTURE
//  counter_seq_pkg: state encoding localparams (S_IDLE..S_DONE), DIV_W default.
//  Sub-module counter_seq_tick: DIV_W prescaler (en, clr, div -> tick), instanced once.
//  Top: FSM, sampled config registers, output decode (busy/done registered from state).
// TESTING
//  1 reset: rst_n=0 mid-RUN -> all outputs 0 immediately, IDLE after release.
//  2 one_shot=1,div=0,target=5: start -> clr 1 cycle, 5 consecutive en, DONE, counter=5, done held.
//  3 one_shot=0,div=3: start -> en every 4th cycle; 17 ticks -> counter wraps to 1, never DONE.
//  4 pause=1 for 10 cycles mid-RUN (div=3) -> no en, tick spacing preserved on resume.
//  5 step x3 in IDLE -> exactly 3 en pulses; step during RUN -> no extra en; start+stop -> IDLE.
//  6 one_shot=1,target=0: start -> clr then DONE, zero en; start in DONE -> restarts via CLEAR.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: shared state encoding and defaults for the counter sequencer
package counter_seq_pkg;
    localparam int DIV_W_DEF = 16;
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STEP, S_RUN, S_PAUSE, S_DONE} state_t;
endpackage

// File: rtl/counter_seq_tick.sv
// counter_seq_tick: prescaler producing one tick every div+1 enabled cycles
module counter_seq_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk_100M,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] presc;
    assign tick = presc == div;
    always_ff @(posedge clk_100M or negedge rst_n)
        if (!rst_n) presc <= '0;
        else if (clr) presc <= '0;
        else if (en) presc <= tick ? '0 : presc + 1'b1;
endmodule

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: start/stop/pause/step sequencer driving counter_en and counter_clr
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk_100M,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             step,
    input  logic             one_shot,
    input  logic [DIV_W-1:0] div,
    input  logic [3:0]       target,
    input  logic [3:0]       counter,
    output logic             counter_en,
    output logic             counter_clr,
    output logic             busy,
    output logic             done
);
    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_q;
    logic [3:0]       target_q;
    logic             one_shot_q;
    logic             tick, hit, presc_en, presc_clr;
    assign hit        = one_shot_q && counter == target_q;
    assign presc_en   = state == S_RUN;
    assign presc_clr  = state == S_CLEAR;
    // enable must see the live counter so a one-shot run stops exactly on target
    assign counter_en = state == S_STEP || (state == S_RUN && tick && !hit);
    counter_seq_tick #(.DIV_W(DIV_W)) u_tick (
        .clk_100M (clk_100M),
        .rst_n    (rst_n),
        .en       (presc_en),
        .clr      (presc_clr),
        .div      (div_q),
        .tick     (tick)
    );
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = stop ? S_IDLE : start ? S_CLEAR : step ? S_STEP : S_IDLE;
            S_CLEAR: state_nxt = stop ? S_IDLE : S_RUN;
            S_STEP:  state_nxt = S_IDLE;
            S_RUN:   state_nxt = stop ? S_IDLE : hit ? S_DONE : pause ? S_PAUSE : S_RUN;
            S_PAUSE: state_nxt = stop ? S_IDLE : pause ? S_PAUSE : S_RUN;
            S_DONE:  state_nxt = stop ? S_IDLE : start ? S_CLEAR : S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk_100M or negedge rst_n)
        if (!rst_n) begin
            state       <= S_IDLE;
            div_q       <= '0;
            target_q    <= '0;
            one_shot_q  <= 1'b0;
            counter_clr <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            counter_clr <= state_nxt == S_CLEAR;
            busy        <= state_nxt inside {S_CLEAR, S_RUN, S_PAUSE, S_STEP};
            done        <= state_nxt == S_DONE;
            if (state_nxt == S_CLEAR) begin
                div_q      <= div;
                target_q   <= target;
                one_shot_q <= one_shot;
            end
        end
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: vector table, directed corner sequences and random run against a reference model
module tb_counter_seq_ctrl;
    typedef struct {
        logic [4:0]  ctl;
        logic [15:0] d;
        logic [3:0]  t;
        logic [3:0]  e;
    } vec_t;
    logic        clk_100M = 1'b0;
    logic        rst_n, start, stop, pause, step, one_shot;
    logic [15:0] div;
    logic [3:0]  target;
    logic [3:0]  cnt = 4'd0;
    logic        counter_en, counter_clr, busy, done;
    int          checks = 0, failures = 0;
    vec_t        tbl[22];
    bit          m_clrq, m_stepq, m_run, m_paused, m_fin, m_os, hit, e_en;
    int          m_phase, m_div;
    logic [3:0]  m_tgt, mcnt;
    int          n_en, first, last, idx;
    bit          dflag;
    always #5 clk_100M = ~clk_100M;
    always @(posedge clk_100M) cnt <= counter_clr ? 4'd0 : counter_en ? cnt + 4'd1 : cnt;
    counter_seq_ctrl dut (
        .clk_100M    (clk_100M),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .step        (step),
        .one_shot    (one_shot),
        .div         (div),
        .target      (target),
        .counter     (cnt),
        .counter_en  (counter_en),
        .counter_clr (counter_clr),
        .busy        (busy),
        .done        (done)
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic vec_t v(input logic [4:0] ctl, input int d, input int t, input logic [3:0] e);
        vec_t r;
        r.ctl = ctl;
        r.d   = 16'(d);
        r.t   = 4'(t);
        r.e   = e;
        return r;
    endfunction
    task automatic cyc();
        @(posedge clk_100M);
        #1;
    endtask
    initial begin
        // ctl = {start, stop, pause, step, one_shot}; e = {en, clr, busy, done}
        tbl[0]  = v(5'b00000, 0, 0, 4'b0000);
        tbl[1]  = v(5'b10001, 0, 2, 4'b0000);
        tbl[2]  = v(5'b00000, 0, 0, 4'b0110);
        tbl[3]  = v(5'b00000, 0, 0, 4'b1010);
        tbl[4]  = v(5'b00000, 0, 0, 4'b1010);
        tbl[5]  = v(5'b00000, 0, 0, 4'b0010);
        tbl[6]  = v(5'b00000, 0, 0, 4'b0001);
        tbl[7]  = v(5'b00010, 0, 0, 4'b0001);
        tbl[8]  = v(5'b00000, 0, 0, 4'b0001);
        tbl[9]  = v(5'b01000, 0, 0, 4'b0001);
        tbl[10] = v(5'b00010, 0, 0, 4'b0000);
        tbl[11] = v(5'b00000, 0, 0, 4'b1010);
        tbl[12] = v(5'b11000, 0, 0, 4'b0000);
        tbl[13] = v(5'b10001, 0, 0, 4'b0000);
        tbl[14] = v(5'b00000, 0, 0, 4'b0110);
        tbl[15] = v(5'b00000, 0, 0, 4'b0010);
        tbl[16] = v(5'b10000, 1, 0, 4'b0001);
        tbl[17] = v(5'b00000, 0, 0, 4'b0110);
        tbl[18] = v(5'b00000, 0, 0, 4'b0010);
        tbl[19] = v(5'b00000, 0, 0, 4'b1010);
        tbl[20] = v(5'b01000, 0, 0, 4'b0010);
        tbl[21] = v(5'b00000, 0, 0, 4'b0000);
        {start, stop, pause, step, one_shot} = 5'b0;
        div = 16'd0;
        target = 4'd0;
        rst_n = 1'b0;
        #23;
        chk("reset_outputs", {counter_en, counter_clr, busy, done}, 4'b0000);
        rst_n = 1'b1;
        cyc();
        for (int i = 0; i < 22; i++) begin
            {start, stop, pause, step, one_shot} = tbl[i].ctl;
            div = tbl[i].d;
            target = tbl[i].t;
            @(negedge clk_100M);
            chk($sformatf("tbl_row%0d", i), {counter_en, counter_clr, busy, done}, tbl[i].e);
            cyc();
        end
        {start, stop, pause, step, one_shot} = 5'b0;
        chk("tbl_cnt", cnt, 4'd1);
        // free-run with div=3: tick every 4th cycle, wrap after 16 increments
        start = 1'b1;
        div = 16'd3;
        n_en = 0;
        first = -1;
        last = -1;
        dflag = 1'b0;
        for (int c = 0; c < 120 && n_en < 17; c++) begin
            @(negedge clk_100M);
            if (done) dflag = 1'b1;
            if (counter_en) begin
                if (n_en == 0) first = c;
                else chk("wrap_gap", c - last, 4);
                last = c;
                n_en++;
            end
            cyc();
            start = 1'b0;
        end
        chk("wrap_first", first, 5);
        chk("wrap_count", n_en, 17);
        chk("wrap_cnt", cnt, 4'd1);
        chk("wrap_done", dflag, 1'b0);
        // pause right after a tick for 10 cycles: next tick shifts by exactly 10
        pause = 1'b1;
        n_en = 0;
        dflag = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_100M);
            if (counter_en) n_en++;
            if (!busy) dflag = 1'b1;
            cyc();
        end
        pause = 1'b0;
        chk("pause_no_en", n_en, 0);
        chk("pause_busy", dflag, 1'b0);
        idx = -1;
        for (int k = 0; k < 20 && idx < 0; k++) begin
            @(negedge clk_100M);
            if (counter_en) idx = k;
            cyc();
        end
        chk("pause_resume", idx, 3);
        // asynchronous reset mid-run
        #1 rst_n = 1'b0;
        #1 chk("rst_async", {counter_en, counter_clr, busy, done}, 4'b0000);
        @(negedge clk_100M);
        rst_n = 1'b1;
        cyc();
        @(negedge clk_100M);
        chk("rst_idle", {counter_en, counter_clr, busy, done}, 4'b0000);
        cyc();
        // randomized run against reference model
        {m_clrq, m_stepq, m_run, m_paused, m_fin, m_os} = 6'b0;
        m_phase = 0;
        m_div = 0;
        m_tgt = 4'd0;
        mcnt = cnt;
        for (int c = 0; c < 3000; c++) begin
            start = $urandom_range(0, 15) == 0;
            stop = $urandom_range(0, 31) == 0;
            step = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 19) == 0) pause = ~pause;
            one_shot = $urandom_range(0, 1) == 1;
            div = 16'($urandom_range(0, 3));
            target = 4'($urandom_range(0, 15));
            @(negedge clk_100M);
            hit = m_os && mcnt == m_tgt;
            e_en = m_stepq || (m_run && !m_paused && m_phase == m_div && !hit);
            chk("rnd_en", counter_en, e_en);
            chk("rnd_clr", counter_clr, m_clrq);
            chk("rnd_busy", busy, m_clrq || m_stepq || m_run);
            chk("rnd_done", done, m_fin);
            chk("rnd_cnt", cnt, mcnt);
            @(posedge clk_100M);
            mcnt = m_clrq ? 4'd0 : e_en ? mcnt + 4'd1 : mcnt;
            if (stop) {m_clrq, m_stepq, m_run, m_paused, m_fin} = 5'b0;
            else if (m_clrq) begin
                m_clrq = 1'b0;
                m_run = 1'b1;
                m_phase = 0;
            end else if (m_stepq) m_stepq = 1'b0;
            else if (m_run && !m_paused) begin
                m_phase = m_phase == m_div ? 0 : m_phase + 1;
                if (hit) begin
                    m_run = 1'b0;
                    m_fin = 1'b1;
                end else if (pause) m_paused = 1'b1;
            end else if (m_run) m_paused = pause;
            else if (start) begin
                m_clrq = 1'b1;
                m_fin = 1'b0;
                m_os = one_shot;
                m_div = int'(div);
                m_tgt = target;
            end else if (step && !m_fin) m_stepq = 1'b1;
            #1;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
